y86_instr_encoder: RTL and testbench
====================================

// Module: y86_instr_encoder
// PURPOSE
//  Write-side counterpart of the fetch stage. Accepts one decoded Y86-64 instruction per
//  transaction (icode, ifun, rA, rB, valC). Serialises it one byte per cycle into a
//  byte-wide instruction-memory write port, at a self-advancing write pointer.
//  Used by loaders and benches to build program images the fetch stage reads back unchanged.
// PARAMETERS
//  ADDR_W  10    instruction-memory address width
//  DEPTH   1024  memory size in bytes; valid addresses are 0..DEPTH-1
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       instruction presented
//  in_ready   out  1       encoder can accept; equals (state==IDLE) & ~overflow
//  icode      in   4       instruction code
//  ifun       in   4       function code
//  rA, rB     in   4 each  register specifiers
//  valC       in   64      constant, displacement or destination
//  ptr_clr    in   1       reset write pointer to 0 and clear overflow (IDLE only)
//  mem_we     out  1       byte write strobe
//  mem_addr   out  ADDR_W  byte address
//  mem_wdata  out  8       byte data
//  wr_ptr     out  ADDR_W+1  next free address (committed bytes)
//  instr_done out  1       1-cycle pulse on the last byte of an instruction
//  bad_instr  out  1       1-cycle pulse: icode > 4'hB rejected
//  overflow   out  1       sticky: instruction would cross DEPTH
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; state IDLE; wr_ptr=0. Reset applies mid-EMIT;
//    bytes already written stay in memory; wr_ptr does NOT advance for the partial instr.
//  Accept: in_valid & in_ready at edge T latches all fields. Length L follows icode:
//    L=1: halt 0, nop 1, ret 9. L=2: cmovxx 2, OPq 6, pushq A, popq B.
//    L=9: jxx 7, call 8. L=10: irmovq 3, rmmovq 4, mrmovq 5.
//  Invalid icode (>B): bad_instr pulses at T+1; no writes; stays IDLE.
//  Overflow: wr_ptr+L > DEPTH sets overflow at T+1 and writes nothing. It holds
//    in_ready=0 until ptr_clr or reset.
//  Byte image: b0={icode,ifun}.
//    L=2 and L=10 add b1={rA,rB}. irmovq forces rA=F; pushq/popq force rB=F.
//    L=10 adds b2..b9 = valC[63:56]..valC[7:0], MS byte first, matching fetch concat.
//    L=9 adds b1..b8 = valC[63:56]..valC[7:0].
//  FSM IDLE -> EMIT (valid, in range) -> IDLE after byte L-1.
//    In EMIT at cycle T+1+k: mem_we=1, mem_addr=base+k, mem_wdata=bk, for k=0..L-1.
//  Last byte: instr_done=1 in the same cycle; wr_ptr=base+L from the next cycle.
//  Latency: first write T+1, last T+L. Next accept no earlier than edge T+L+1.
//  All outputs are registered. mem_we=0 whenever not in EMIT; mem_addr/mem_wdata hold.
//  ptr_clr is ignored outside IDLE. ptr_clr with in_valid in the same cycle: clear wins,
//    and the instruction is not accepted that cycle.
//  wr_ptr==DEPTH is legal (memory full); any further accept sets overflow.
// STRUCTURE
//  y86_pkg: icode localparams (HALT..POPQ), REG_NONE=4'hF, function instr_len(icode)
//    returning 0 for invalid. Share with fetch.
//  Sub-module y86_instr_pack: combinational; fields -> 80-bit byte image + L.
//  Top: FSM, byte index counter, pointer and flags.
// TESTING
//  1 reset, nop at ptr 0 -> one write addr0 data 10; instr_done same cycle; wr_ptr=1.
//  2 irmovq rB=2 valC=0x0102030405060708 at ptr 1 -> addrs 1..10: 30 F2 01 02 ... 08;
//    wr_ptr=11.
//  3 call valC=0x40 at ptr 11 -> 9 writes: 80 00x7 40; wr_ptr=20; fetch round-trip
//    valP=20.
//  4 icode=C -> bad_instr pulse; mem_we stays 0; wr_ptr unchanged; in_ready stays 1.
//  5 wr_ptr=1020, mrmovq -> overflow=1, no writes, in_ready=0. ptr_clr -> wr_ptr=0,
//    in_ready=1.
//  6 reset asserted at byte 4 of rmmovq -> mem_we=0 next cycle; wr_ptr=0; in_ready=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 instruction-set constants. Used by the encoder and the fetch stage.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  // Register specifier meaning "no register"
  localparam logic [3:0] REG_NONE = 4'hF;

  // Encoder control states
  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } enc_state_t;

  // Encoded length in bytes; 0 flags an icode outside the instruction set.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      HALT, NOP, RET:                return 4'd1;
      CMOVXX, OPQ, PUSHQ, POPQ:      return 4'd2;
      JXX, CALL:                     return 4'd9;
      IRMOVQ, RMMOVQ, MRMOVQ:        return 4'd10;
      default:                       return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_pack.sv
// Combinational packer: decoded fields -> byte image (byte 0 in bits 79:72) and length.
// Unused trailing bytes of the image are zero.
module y86_instr_pack
  import y86_pkg::*;
(
  input  logic [3:0]  i_icode,
  input  logic [3:0]  i_ifun,
  input  logic [3:0]  i_ra,
  input  logic [3:0]  i_rb,
  input  logic [63:0] i_valc,
  output logic [79:0] o_img,
  output logic [3:0]  o_len
);

  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [7:0] w_b0;
  logic [7:0] w_regs;

  // irmovq has no source register; push/pop have no second register.
  assign w_ra   = (i_icode == IRMOVQ) ? REG_NONE : i_ra;
  assign w_rb   = (i_icode == PUSHQ || i_icode == POPQ) ? REG_NONE : i_rb;
  assign w_b0   = {i_icode, i_ifun};
  assign w_regs = {w_ra, w_rb};
  assign o_len  = instr_len(i_icode);

  // Assemble the image; valC goes most-significant byte first, as fetch concatenates it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_img = '0;
    case (o_len)
      4'd1:    o_img = {w_b0, 72'h0};
      4'd2:    o_img = {w_b0, w_regs, 64'h0};
      4'd9:    o_img = {w_b0, i_valc, 8'h0};
      4'd10:   o_img = {w_b0, w_regs, i_valc};
      default: o_img = '0;
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction per transaction into a byte-wide
// instruction-memory write port at a self-advancing write pointer.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              ptr_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              instr_done,
  output logic              bad_instr,
  output logic              overflow
);

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  enc_state_t        r_state, w_state;
  logic [79:0]       r_img, w_img;       // remaining bytes, next one in 79:72
  logic [3:0]        r_len, w_len;
  logic [3:0]        r_idx, w_idx;       // bytes already presented
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [7:0]        r_wdata, w_wdata;
  logic [ADDR_W:0]   r_ptr, w_ptr;
  logic              r_done, w_done;
  logic              r_bad, w_bad;
  logic              r_ovf, w_ovf;

  logic [79:0]       w_pack_img;
  logic [3:0]        w_pack_len;
  logic              w_ready;
  logic [ADDR_W+1:0] w_end;              // one past the last byte if accepted

  y86_instr_pack u_pack (
    .i_icode (icode),
    .i_ifun  (ifun),
    .i_ra    (rA),
    .i_rb    (rB),
    .i_valc  (valC),
    .o_img   (w_pack_img),
    .o_len   (w_pack_len)
  );

  assign w_ready = (r_state == ST_IDLE) && !r_ovf;
  assign w_end   = {1'b0, r_ptr} + {{(ADDR_W-2){1'b0}}, w_pack_len};

  // Next-state and next-output logic for the accept / emit sequence.
  always_comb begin
    w_state = r_state;
    w_img   = r_img;
    w_len   = r_len;
    w_idx   = r_idx;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_ptr   = r_ptr;
    w_done  = 1'b0;
    w_bad   = 1'b0;
    w_ovf   = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (ptr_clr) begin
          // Clear takes priority over a simultaneous instruction.
          w_ptr = '0;
          w_ovf = 1'b0;
        end else if (in_valid && w_ready) begin
          if (w_pack_len == 4'd0) begin
            w_bad = 1'b1;
          end else if (w_end > DEPTH_W) begin
            w_ovf = 1'b1;
          end else begin
            // Byte 0 goes out on the accepting edge; the rest shift up behind it.
            w_state = ST_EMIT;
            w_we    = 1'b1;
            w_addr  = r_ptr[ADDR_W-1:0];
            w_wdata = w_pack_img[79:72];
            w_img   = {w_pack_img[71:0], 8'h00};
            w_len   = w_pack_len;
            w_idx   = 4'd1;
            w_done  = (w_pack_len == 4'd1);
          end
        end
      end
      ST_EMIT: begin
        if (r_idx == r_len) begin
          // Last byte was presented last cycle: commit the pointer.
          w_state = ST_IDLE;
          w_ptr   = r_ptr + {{(ADDR_W-3){1'b0}}, r_len};
        end else begin
          w_we    = 1'b1;
          w_addr  = r_addr + ADDR_W'(1);
          w_wdata = r_img[79:72];
          w_img   = {r_img[71:0], 8'h00};
          w_idx   = r_idx + 4'd1;
          w_done  = (r_idx == r_len - 4'd1);
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons a partial instruction without committing it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state <= ST_IDLE;
      r_img   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ptr   <= '0;
      r_done  <= 1'b0;
      r_bad   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_img   <= w_img;
      r_len   <= w_len;
      r_idx   <= w_idx;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_ptr   <= w_ptr;
      r_done  <= w_done;
      r_bad   <= w_bad;
      r_ovf   <= w_ovf;
    end
  end

  assign in_ready   = w_ready;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign wr_ptr     = r_ptr;
  assign instr_done = r_done;
  assign bad_instr  = r_bad;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: a transaction-level model predicts every byte write,
// pointer value and flag; a negedge process compares the DUT against it each cycle.
module tb_y86_instr_encoder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        ptr_clr = 1'b0;
  logic [3:0]  icode = '0, ifun = '0, ra = '0, rb = '0;
  logic [63:0] valc = '0;
  logic        in_ready, mem_we, instr_done, bad_instr, overflow;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [10:0] wr_ptr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  y86_instr_encoder #(.ADDR_W(10), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (ra),
    .rB         (rb),
    .valC       (valc),
    .ptr_clr    (ptr_clr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .wr_ptr     (wr_ptr),
    .instr_done (instr_done),
    .bad_instr  (bad_instr),
    .overflow   (overflow)
  );

  // ---------------- model ----------------
  typedef struct {
    int         addr;
    logic [7:0] data;
    bit         last;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        cur;
  int         m_ptr = 0;
  int         m_busy = 0;
  bit         m_ovf = 1'b0;
  bit         m_bad = 1'b0;
  bit         m_live = 1'b0;
  logic [7:0] mem_img [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int spec_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:             return 1;
      4'h2, 4'h6, 4'hA, 4'hB:       return 2;
      4'h7, 4'h8:                   return 9;
      4'h3, 4'h4, 4'h5:             return 10;
      default:                      return 0;
    endcase
  endfunction

  task automatic model_accept(input int len);
    logic [7:0] b[$];
    logic [3:0] a;
    logic [3:0] bb;
    wr_t        w;
    a  = (icode == 4'h3) ? 4'hF : ra;
    bb = (icode == 4'hA || icode == 4'hB) ? 4'hF : rb;
    b.push_back({icode, ifun});
    if (len == 2 || len == 10) b.push_back({a, bb});
    if (len >= 9)
      for (int i = 7; i >= 0; i--) b.push_back(valc[8*i +: 8]);
    for (int k = 0; k < b.size(); k++) begin
      w.addr = m_ptr + k;
      w.data = b[k];
      w.last = (k == len - 1);
      exp_q.push_back(w);
    end
    m_ptr  = m_ptr + len;
    m_busy = len;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_busy = 0;
      m_ptr  = 0;
      m_ovf  = 1'b0;
      m_bad  = 1'b0;
      m_live = 1'b1;
    end else begin
      m_bad = 1'b0;
      if (m_busy != 0) begin
        m_busy--;
      end else if (ptr_clr) begin
        m_ptr = 0;
        m_ovf = 1'b0;
      end else if (in_valid && !m_ovf) begin
        if (spec_len(icode) == 0) m_bad = 1'b1;
        else if (m_ptr + spec_len(icode) > DEPTH) m_ovf = 1'b1;
        else model_accept(spec_len(icode));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("mem_we", mem_we, m_busy != 0);
      check("in_ready", in_ready, (m_busy == 0) && !m_ovf);
      check("overflow", overflow, m_ovf);
      check("bad_instr", bad_instr, m_bad);
      if (mem_we) begin
        mem_img[mem_addr] = mem_wdata;
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wdata", mem_wdata, cur.data);
          check("instr_done", instr_done, cur.last);
        end
      end else begin
        check("instr_done_idle", instr_done, 1'b0);
        if (m_busy == 0) check("wr_ptr", wr_ptr, m_ptr);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_idle();
    while (m_busy != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] c, input bit clr);
    wait_idle();
    icode    = ic;
    ifun     = fn;
    ra       = a;
    rb       = b;
    valc     = c;
    in_valid = 1'b1;
    ptr_clr  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ptr_clr  = 1'b0;
  endtask

  task automatic fill_to(input int target);
    while (m_ptr < target) begin
      if (target - m_ptr >= 10) send(4'h3, 4'h0, 4'h0, 4'($urandom_range(0, 14)), {$urandom, $urandom}, 1'b0);
      else send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
      wait_idle();
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wr_ptr", wr_ptr, 11'd0);
    check("rst_mem_we", mem_we, 1'b0);

    // nop at 0
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    wait_idle();
    check("nop_byte0", mem_img[0], 8'h10);
    check("nop_wr_ptr", wr_ptr, 11'd1);

    // irmovq rB=2 at 1
    send(4'h3, 4'h0, 4'h5, 4'h2, 64'h0102030405060708, 1'b0);
    wait_idle();
    check("irm_b0", mem_img[1], 8'h30);
    check("irm_b1", mem_img[2], 8'hF2);
    check("irm_b2", mem_img[3], 8'h01);
    check("irm_b9", mem_img[10], 8'h08);
    check("irm_wr_ptr", wr_ptr, 11'd11);

    // call 0x40 at 11, with ptr_clr held while emitting (must be ignored)
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h40, 1'b0);
    ptr_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ptr_clr = 1'b0;
    wait_idle();
    check("call_b0", mem_img[11], 8'h80);
    check("call_b1", mem_img[12], 8'h00);
    check("call_b7", mem_img[18], 8'h00);
    check("call_b8", mem_img[19], 8'h40);
    check("call_valp", wr_ptr, 11'd20);

    // invalid icode
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    check("bad_pulse", bad_instr, 1'b1);
    check("bad_no_write", mem_we, 1'b0);
    check("bad_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("bad_ptr", wr_ptr, 11'd20);

    // one of each remaining form, forced specifiers included
    send(4'h2, 4'h3, 4'h1, 4'h2, 64'h0, 1'b0);
    send(4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 1'b0);
    send(4'hA, 4'h0, 4'h7, 4'h3, 64'h0, 1'b0);
    send(4'hB, 4'h0, 4'h8, 4'h1, 64'h0, 1'b0);
    send(4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    send(4'h7, 4'h4, 4'h0, 4'h0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h8877665544332211, 1'b0);
    send(4'h5, 4'h0, 4'h3, 4'h6, 64'hFFFF_0000_1234_5678, 1'b0);
    wait_idle();
    check("push_regs", mem_img[25], 8'h7F);
    check("jxx_b0", mem_img[30], 8'h74);

    // fill to 1020, then an instruction that would cross the end
    fill_to(1020);
    check("fill_ptr", wr_ptr, 11'd1020);
    send(4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_ready", in_ready, 1'b0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_ptr", wr_ptr, 11'd1020);

    // clear wins over a simultaneous instruction
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1);
    check("clr_ptr", wr_ptr, 11'd0);
    check("clr_ovf", overflow, 1'b0);
    check("clr_ready", in_ready, 1'b1);
    check("clr_no_write", mem_we, 1'b0);

    // fill exactly to DEPTH (legal), then any accept overflows
    fill_to(1014);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h0, 1'b0);
    wait_idle();
    check("full_ptr", wr_ptr, 11'd1024);
    check("full_no_ovf", overflow, 1'b0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    check("full_ovf", overflow, 1'b1);

    // reset in the middle of an rmmovq
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'hA1A2A3A4A5A6A7A8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_addr", mem_addr, 10'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_ptr", wr_ptr, 11'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_kept_b1", mem_img[1], 8'h12);
    check("mid_kept_b4", mem_img[4], 8'hA3);

    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    wait_idle();
    check("post_rst_ptr", wr_ptr, 11'd1);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
